maxpool_engine_kxk: RTL and testbench

- Streaming, channel-parallel max-pool engine for generic non-overlapping KH x KW windows (1..K_MAX each, stride = kernel) over a raster-ordered feature map of runtime width/height.
- Sits between the conv output pipeline and the output DMA packer.
- Adds over the current fixed 2x2 engine: full AXI-stream backpressure (m_ready), runtime kernel and image geometry, line-buffered vertical reduction, and frame-level framing checks.

---
 rtl/maxpool_engine_kxk.sv | 242 ++++++++++++++++++++++++
 tb/tb_maxpool_engine_kxk.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/maxpool_engine_kxk.sv
// Streaming channel-parallel KH x KW max-pool engine (stride = kernel).
// The horizontal reduction runs in an accumulator. The vertical reduction uses
// a line buffer with one entry per output column. There is a single output
// register with full valid/ready backpressure.
// Optional feature macro: MAXPOOL_AVG_EN adds cfg_avg, which selects 2x2
// average pooling using a sum widened by two bits.
module maxpool_engine_kxk #(
  parameter int unsigned LANES      = 16,
  parameter int unsigned WORD_WIDTH = 8,
  parameter int unsigned K_MAX      = 4,
  parameter int unsigned W_MAX      = 256,
  parameter int unsigned H_MAX      = 256,
  parameter int unsigned KB         = $clog2(K_MAX + 1),
  parameter int unsigned WB         = $clog2(W_MAX + 1),
  parameter int unsigned HB         = $clog2(H_MAX + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clken,
  input  logic [KB-1:0]               cfg_kh,
  input  logic [KB-1:0]               cfg_kw,
  input  logic [WB-1:0]               cfg_width,
  input  logic [HB-1:0]               cfg_height,
`ifdef MAXPOOL_AVG_EN
  input  logic                        cfg_avg,
`endif
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [LANES*WORD_WIDTH-1:0] s_data,
  input  logic                        s_last,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [LANES*WORD_WIDTH-1:0] m_data,
  output logic                        m_last,
  output logic                        err_frame,
  output logic                        debug_state
);

`ifdef MAXPOOL_AVG_EN
  localparam int unsigned AW = WORD_WIDTH + 2;
`else
  localparam int unsigned AW = WORD_WIDTH;
`endif
  localparam int unsigned LBA = (W_MAX > 1) ? $clog2(W_MAX) : 1;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e            state_q, state_d;
  logic [KB-1:0]     kh_q, kw_q, kh_e, kw_e;
  logic [WB-1:0]     width_q, width_e;
  logic [HB-1:0]     height_q, height_e;
  logic              avg_e;
  logic [WB-1:0]     col_q, col_d;
  logic [HB-1:0]     row_q, row_d;
  logic [KB-1:0]     kx_q, kx_d, ky_q, ky_d;
  logic [LBA-1:0]    ox_q, ox_d;
  logic              h_in_q, v_in_q, h_in, v_in;
  logic              col_last, row_last, kx_last, ky_last, frame_end;
  logic              last_win, win_done, lb_we, s_hs, m_hs;
  logic [LANES*AW-1:0]         hacc_q, h_val, v_val, lb_rd;
  logic [LANES*WORD_WIDTH-1:0] v_out;
  logic [LANES*AW-1:0]         linebuf [W_MAX];

`ifdef MAXPOOL_AVG_EN
  logic avg_q;
  assign avg_e = (state_q == StIdle) ? cfg_avg : avg_q;
`else
  assign avg_e = 1'b0;
`endif

  // Lanewise reduction: signed max, or signed sum in average mode.
  function automatic logic signed [AW-1:0] lane_op(input logic signed [AW-1:0] a,
                                                   input logic signed [AW-1:0] b,
                                                   input logic avg);
    if (avg) return a + b;
    return (a > b) ? a : b;
  endfunction

  assign s_ready = clken & (~m_valid | m_ready);
  assign s_hs    = clken & s_valid & s_ready;
  assign m_hs    = clken & m_valid & m_ready;

  // The first beat of a frame uses the live config; later beats use the latched copy.
  assign kh_e     = (state_q == StIdle) ? cfg_kh     : kh_q;
  assign kw_e     = (state_q == StIdle) ? cfg_kw     : kw_q;
  assign width_e  = (state_q == StIdle) ? cfg_width  : width_q;
  assign height_e = (state_q == StIdle) ? cfg_height : height_q;

  assign lb_rd = linebuf[ox_q];

  // Window-fit flags replace a division for OW/OH. A window is pooled only
  // if it fits entirely inside the image, which is checked when it starts.
  always_comb begin
    col_last  = (col_q + WB'(1)) == width_e;
    row_last  = (row_q + HB'(1)) == height_e;
    kx_last   = (kx_q + KB'(1)) == kw_e;
    ky_last   = (ky_q + KB'(1)) == kh_e;
    frame_end = row_last & col_last;
    h_in      = (kx_q == '0) ?
                (({1'b0, col_q} + (WB+1)'(kw_e)) <= {1'b0, width_e}) : h_in_q;
    v_in      = (ky_q == '0 && col_q == '0) ?
                (({1'b0, row_q} + (HB+1)'(kh_e)) <= {1'b0, height_e}) : v_in_q;
    last_win  = (({1'b0, col_q} + (WB+1)'(kw_e)) >= {1'b0, width_e}) &&
                (({1'b0, row_q} + (HB+1)'(kh_e)) >= {1'b0, height_e});
    win_done  = s_hs & h_in & v_in & kx_last & ky_last;
    lb_we     = s_hs & h_in & v_in & kx_last & ~ky_last;
  end

  // Lanewise horizontal and vertical reduction, plus output scaling.
  always_comb begin
    logic signed [AW-1:0] s_l, h_l, v_l;
    h_val = '0;
    v_val = '0;
    v_out = '0;
    for (int l = 0; l < LANES; l++) begin
      s_l = AW'($signed(s_data[l*WORD_WIDTH +: WORD_WIDTH]));
      h_l = (kx_q == '0) ? s_l : lane_op(hacc_q[l*AW +: AW], s_l, avg_e);
      v_l = (ky_q == '0) ? h_l : lane_op(h_l, lb_rd[l*AW +: AW], avg_e);
      h_val[l*AW +: AW] = h_l;
      v_val[l*AW +: AW] = v_l;
`ifdef MAXPOOL_AVG_EN
      v_out[l*WORD_WIDTH +: WORD_WIDTH] = avg_e ? WORD_WIDTH'(v_l >>> 2)
                                                : v_l[WORD_WIDTH-1:0];
`else
      v_out[l*WORD_WIDTH +: WORD_WIDTH] = v_l;
`endif
    end
  end

  // Raster and window counters advance on every accepted input beat.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    kx_d  = kx_q;
    ky_d  = ky_q;
    ox_d  = ox_q;
    if (frame_end) begin
      col_d = '0;
      row_d = '0;
      kx_d  = '0;
      ky_d  = '0;
      ox_d  = '0;
    end else if (col_last) begin
      col_d = '0;
      row_d = row_q + HB'(1);
      kx_d  = '0;
      ox_d  = '0;
      // Rows below the pooled area leave ky untouched.
      if (v_in) ky_d = ky_last ? '0 : ky_q + KB'(1);
    end else begin
      col_d = col_q + WB'(1);
      kx_d  = kx_last ? '0 : kx_q + KB'(1);
      ox_d  = kx_last ? ox_q + LBA'(1) : ox_q;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // FSM next state: a frame runs from its first beat to the beat at (H-1, W-1).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (s_hs && !frame_end) state_d = StRun;
      StRun:   if (s_hs && frame_end)  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    debug_state = (state_q == StRun);
  end

  // Counters, config latch and horizontal accumulator.
  always_ff @(posedge clk) begin
    if (reset) begin
      col_q    <= '0;
      row_q    <= '0;
      kx_q     <= '0;
      ky_q     <= '0;
      ox_q     <= '0;
      h_in_q   <= 1'b0;
      v_in_q   <= 1'b0;
      hacc_q   <= '0;
      kh_q     <= '0;
      kw_q     <= '0;
      width_q  <= '0;
      height_q <= '0;
`ifdef MAXPOOL_AVG_EN
      avg_q    <= 1'b0;
`endif
    end else if (s_hs) begin
      col_q  <= col_d;
      row_q  <= row_d;
      kx_q   <= kx_d;
      ky_q   <= ky_d;
      ox_q   <= ox_d;
      h_in_q <= h_in;
      v_in_q <= v_in;
      hacc_q <= h_val;
      if (state_q == StIdle) begin
        kh_q     <= cfg_kh;
        kw_q     <= cfg_kw;
        width_q  <= cfg_width;
        height_q <= cfg_height;
`ifdef MAXPOOL_AVG_EN
        avg_q    <= cfg_avg;
`endif
      end
    end
  end

  // Line buffer holds partial vertical results per output column.
  always_ff @(posedge clk) begin
    if (lb_we) linebuf[ox_q] <= v_val;
  end

  // Output register; a new window result may replace the one being taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid   <= 1'b0;
      m_data    <= '0;
      m_last    <= 1'b0;
      err_frame <= 1'b0;
    end else begin
      if (win_done) begin
        m_valid <= 1'b1;
        m_data  <= v_out;
        m_last  <= last_win;
      end else if (m_hs) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end
      if (s_hs && (s_last != frame_end)) err_frame <= 1'b1;
    end
  end

endmodule

// File: tb/tb_maxpool_engine_kxk.sv
// Self-checking bench for maxpool_engine_kxk: table of frame cases with a
// window-max reference model feeding a scoreboard, plus hand sequences.
module tb_maxpool_engine_kxk;

  localparam int unsigned LANES = 2;
  localparam int unsigned WW    = 8;
  localparam int unsigned K_MAX = 4;
  localparam int unsigned W_MAX = 16;
  localparam int unsigned H_MAX = 16;
  localparam int unsigned KB    = $clog2(K_MAX + 1);
  localparam int unsigned WB    = $clog2(W_MAX + 1);
  localparam int unsigned HB    = $clog2(H_MAX + 1);

  logic                clk = 1'b0;
  logic                reset, clken;
  logic [KB-1:0]       cfg_kh, cfg_kw;
  logic [WB-1:0]       cfg_width;
  logic [HB-1:0]       cfg_height;
  logic                cfg_avg;
  logic                s_valid, s_ready, s_last;
  logic [LANES*WW-1:0] s_data, m_data;
  logic                m_valid, m_ready, m_last, err_frame, debug_state;

  maxpool_engine_kxk #(
    .LANES(LANES), .WORD_WIDTH(WW), .K_MAX(K_MAX), .W_MAX(W_MAX), .H_MAX(H_MAX)
  ) dut (
    .clk(clk), .reset(reset), .clken(clken),
    .cfg_kh(cfg_kh), .cfg_kw(cfg_kw), .cfg_width(cfg_width), .cfg_height(cfg_height),
`ifdef MAXPOOL_AVG_EN
    .cfg_avg(cfg_avg),
`endif
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .err_frame(err_frame), .debug_state(debug_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kh, kw, w, h;
    int pat;      // 0: r*w+c, 1: -(r*w+c), 2: random
    int rdy;      // m_ready probability, percent
    int gap;      // s_valid gap probability, percent
    int bad;      // beat index carrying a stray s_last, -1 for correct framing
  } case_t;

  typedef struct packed {
    logic [LANES*WW-1:0] data;
    logic                last;
  } exp_t;

  case_t cases [9];
  exp_t  sb [$];
  byte   pix0 [H_MAX][W_MAX];
  byte   pix1 [H_MAX][W_MAX];
  int    n_vec = 0;
  int    n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b0; clken = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("reset m_valid", 32'(m_valid), 32'd0);
    chk("reset m_data", 32'(m_data), 32'd0);
    chk("reset m_last", 32'(m_last), 32'd0);
    chk("reset err_frame", 32'(err_frame), 32'd0);
    chk("reset debug_state", 32'(debug_state), 32'd0);
    chk("reset s_ready", 32'(s_ready), 32'd1);
  endtask

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic drive_beat(input logic [LANES*WW-1:0] d, input logic l);
    logic got;
    got = 1'b0;
    s_valid = 1'b1; s_data = d; s_last = l;
    for (int t = 0; t < 500 && !got; t++) begin
      #4 got = s_ready;
      @(negedge clk);
    end
    if (!got) begin
      n_err++;
      $display("FAIL input handshake timeout: got s_ready 0 expected 1");
    end
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  // Reference model: direct window maxima over the stored frame.
  task automatic build_case(input case_t tc);
    int v;
    byte m0, m1;
    exp_t e;
    sb.delete();
    for (int r = 0; r < tc.h; r++)
      for (int c = 0; c < tc.w; c++) begin
        if (tc.pat == 0)      v = r * tc.w + c;
        else if (tc.pat == 1) v = -(r * tc.w + c);
        else                  v = int'($urandom_range(255));
        pix0[r][c] = byte'(v);
        pix1[r][c] = byte'($urandom_range(255));
      end
    for (int oy = 0; oy < tc.h / tc.kh; oy++)
      for (int ox = 0; ox < tc.w / tc.kw; ox++) begin
        m0 = -128; m1 = -128;
        for (int dy = 0; dy < tc.kh; dy++)
          for (int dx = 0; dx < tc.kw; dx++) begin
            if (pix0[oy*tc.kh+dy][ox*tc.kw+dx] > m0) m0 = pix0[oy*tc.kh+dy][ox*tc.kw+dx];
            if (pix1[oy*tc.kh+dy][ox*tc.kw+dx] > m1) m1 = pix1[oy*tc.kh+dy][ox*tc.kw+dx];
          end
        e.data = {m1, m0};
        e.last = (oy == tc.h / tc.kh - 1) && (ox == tc.w / tc.kw - 1);
        sb.push_back(e);
      end
  endtask

  task automatic monitor(input int n_exp, input int rdy);
    int   got = 0;
    logic held_v = 1'b0;
    logic [LANES*WW-1:0] held;
    exp_t e;
    for (int cyc = 0; cyc < 4000 && got < n_exp; cyc++) begin
      m_ready = ($urandom_range(99) < rdy);
      #4;
      if (held_v) begin
        chk("m_valid held", 32'(m_valid), 32'd1);
        chk("m_data stable", 32'(m_data), 32'(held));
      end
      held_v = 1'b0;
      if (m_valid) begin
        if (m_ready) begin
          if (sb.size() == 0) begin
            n_err++;
            $display("FAIL extra output: got %0h expected none", m_data);
          end else begin
            e = sb.pop_front();
            chk("m_data", 32'(m_data), 32'(e.data));
            chk("m_last", 32'(m_last), 32'(e.last));
          end
          got++;
        end else begin
          chk("s_ready backpressure", 32'(s_ready), 32'd0);
          held = m_data; held_v = 1'b1;
        end
      end
      @(negedge clk);
    end
    if (got < n_exp) begin
      n_err++;
      $display("FAIL output timeout: got %0d beats expected %0d", got, n_exp);
    end
    m_ready = 1'b0;
  endtask

  task automatic driver(input case_t tc);
    int beat = 0;
    logic l;
    for (int r = 0; r < tc.h; r++)
      for (int c = 0; c < tc.w; c++) begin
        if ($urandom_range(99) < tc.gap) @(negedge clk);
        l = (tc.bad >= 0) ? (beat == tc.bad) : (r == tc.h - 1 && c == tc.w - 1);
        drive_beat({pix1[r][c], pix0[r][c]}, l);
        beat++;
      end
  endtask

  task automatic run_case(input case_t tc);
    int n;
    do_reset();
    cfg_kh = KB'(tc.kh); cfg_kw = KB'(tc.kw);
    cfg_width = WB'(tc.w); cfg_height = HB'(tc.h);
    build_case(tc);
    n = sb.size();
    fork
      driver(tc);
      monitor(n, tc.rdy);
    join
    repeat (4) @(negedge clk);
    chk("no extra m_valid", 32'(m_valid), 32'd0);
    chk("scoreboard drained", 32'(sb.size()), 32'd0);
    chk("idle after frame", 32'(debug_state), 32'd0);
    chk("err_frame", 32'(err_frame), 32'(tc.bad >= 0));
  endtask

  initial begin
    reset = 1'b1; clken = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    m_ready = 1'b0; cfg_avg = 1'b0;
    cfg_kh = '0; cfg_kw = '0; cfg_width = '0; cfg_height = '0;

    cases[0] = '{kh: 2, kw: 2, w: 4, h: 4, pat: 0, rdy: 100, gap: 0,  bad: -1};
    cases[1] = '{kh: 3, kw: 3, w: 7, h: 6, pat: 0, rdy: 100, gap: 0,  bad: -1};
    cases[2] = '{kh: 2, kw: 2, w: 4, h: 4, pat: 1, rdy: 100, gap: 0,  bad: -1};
    cases[3] = '{kh: 2, kw: 2, w: 4, h: 4, pat: 0, rdy: 50,  gap: 0,  bad: -1};
    cases[4] = '{kh: 1, kw: 1, w: 3, h: 1, pat: 0, rdy: 100, gap: 0,  bad: 1};
    cases[5] = '{kh: 2, kw: 3, w: 8, h: 5, pat: 2, rdy: 50,  gap: 30, bad: -1};
    cases[6] = '{kh: 4, kw: 4, w: 9, h: 9, pat: 2, rdy: 70,  gap: 10, bad: -1};
    cases[7] = '{kh: 3, kw: 1, w: 4, h: 7, pat: 2, rdy: 30,  gap: 20, bad: -1};
    cases[8] = '{kh: 1, kw: 4, w: 8, h: 3, pat: 2, rdy: 60,  gap: 0,  bad: -1};

    for (int i = 0; i < 9; i++) begin
      run_case(cases[i]);
      if (i == 4) begin
        repeat (5) @(negedge clk);
        chk("err_frame sticky", 32'(err_frame), 32'd1);
      end
    end

    // Held output, clken freeze and mid-frame reset.
    do_reset();
    cfg_kh = 2; cfg_kw = 2; cfg_width = 2; cfg_height = 2;
    drive_beat(16'h0301, 1'b0);
    drive_beat(16'h0402, 1'b0);
    drive_beat(16'h8003, 1'b0);
    drive_beat(16'h7F09, 1'b1);
    #4;
    chk("held m_valid", 32'(m_valid), 32'd1);
    chk("held m_data", 32'(m_data), 32'h7F09);
    chk("held m_last", 32'(m_last), 32'd1);
    chk("held s_ready", 32'(s_ready), 32'd0);
    @(negedge clk);
    clken = 1'b0; m_ready = 1'b1;
    #4 chk("clken low s_ready", 32'(s_ready), 32'd0);
    @(negedge clk);
    chk("clken low m_valid", 32'(m_valid), 32'd1);
    clken = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    chk("drained m_valid", 32'(m_valid), 32'd0);
    drive_beat(16'h1111, 1'b0);
    drive_beat(16'h2222, 1'b0);
    chk("mid-frame run", 32'(debug_state), 32'd1);
    do_reset();
    cfg_kh = 1; cfg_kw = 1; cfg_width = 1; cfg_height = 1;
    drive_beat(16'h5A55, 1'b1);
    #4;
    chk("restart m_valid", 32'(m_valid), 32'd1);
    chk("restart m_data", 32'(m_data), 32'h5A55);
    chk("restart m_last", 32'(m_last), 32'd1);
    chk("restart err_frame", 32'(err_frame), 32'd0);
    chk("restart idle", 32'(debug_state), 32'd0);

`ifdef MAXPOOL_AVG_EN
    // 2x2 average: lane0 {-1,-2,3,5} -> 1, lane1 {-1,-1,-1,-2} -> -2.
    do_reset();
    cfg_avg = 1'b1; cfg_kh = 2; cfg_kw = 2; cfg_width = 2; cfg_height = 2;
    drive_beat(16'hFFFF, 1'b0);
    drive_beat(16'hFFFE, 1'b0);
    drive_beat(16'hFF03, 1'b0);
    drive_beat(16'hFE05, 1'b1);
    #4;
    chk("avg m_valid", 32'(m_valid), 32'd1);
    chk("avg m_data", 32'(m_data), 32'hFE01);
    cfg_avg = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
